cam_capture: RTL

- Receives OV7670 parallel pixel bus signals on the camera GPIO header.
- Oversamples them in the system clock domain and reassembles byte pairs into RGB565 pixels.
- Emits a pixel stream with coordinates and frame/line markers.
- Sits directly downstream of the board-level pin mapping and upstream of the SDRAM write path and Sobel stage.

---
 rtl/cam_pkg.sv | 21 ++
 rtl/cam_capture_if.sv | 37 +++
 rtl/cam_sync_edge.sv | 34 +++
 rtl/cam_capture.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and default geometry for the OV7670 capture front end.
`timescale 1ns/1ps
package cam_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VS,
    SKIP,
    ACTIVE
  } cam_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/cam_capture_if.sv
// Camera pin bundle plus the reassembled pixel stream of cam_capture.
`timescale 1ns/1ps
interface cam_capture_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
);
  import cam_pkg::*;

  logic          capture_en_i;
  logic          cam_pclk;
  logic          cam_vsync;
  logic          cam_href;
  logic [7:0]    cam_data;
  logic          pixel_valid_o;
  rgb565_t       pixel_data_o;
  logic [XW-1:0] pixel_x_o;
  logic [YW-1:0] pixel_y_o;
  logic          sof_o;
  logic          eol_o;
  logic          frame_done_o;
  logic          line_err_o;
  logic          frame_err_o;
  logic          busy_o;

  modport master (
    input  capture_en_i, cam_pclk, cam_vsync, cam_href, cam_data,
    output pixel_valid_o, pixel_data_o, pixel_x_o, pixel_y_o, sof_o, eol_o,
           frame_done_o, line_err_o, frame_err_o, busy_o
  );

  modport slave (
    output capture_en_i, cam_pclk, cam_vsync, cam_href, cam_data,
    input  pixel_valid_o, pixel_data_o, pixel_x_o, pixel_y_o, sof_o, eol_o,
           frame_done_o, line_err_o, frame_err_o, busy_o
  );

endinterface

// File: rtl/cam_sync_edge.sv
// 2-FF synchroniser with a third history flop for rise/fall detection.
`timescale 1ns/1ps
module cam_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] sync,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta;
  logic [W-1:0] stage;
  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= '0;
      stage <= '0;
      prev  <= '0;
    end else begin
      meta  <= d;
      stage <= meta;
      prev  <= stage;
    end
  end

  assign sync = stage;
  assign rise = stage & ~prev;
  assign fall = ~stage & prev;

endmodule

// File: rtl/cam_capture.sv
// OV7670 byte-pair capture: oversampled pins -> RGB565 pixel stream with coordinates.
`timescale 1ns/1ps
module cam_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned FRAME_SKIP = 2,
  parameter int unsigned XW         = 10,
  parameter int unsigned YW         = 9
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  cam_capture_if.master bus
);

  localparam logic [XW:0] X_END  = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0] X_LAST = (XW+1)'(H_ACTIVE - 1);
  localparam logic [YW:0] Y_END  = (YW+1)'(V_ACTIVE);
  localparam logic [7:0]  SKIP_N = 8'(FRAME_SKIP);

  logic rst_meta, rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) {rst_meta, rst_n} <= '0;
    else         {rst_meta, rst_n} <= {1'b1, rst_meta};
  end

  logic [2:0] ctl_sync, ctl_rise, ctl_fall;
  logic [7:0] data_sync, data_rise, data_fall;
  logic       unused_bits;

  cam_sync_edge #(.W(3)) u_ctl_sync (
    .clk(clk_i), .rst_n(rst_n), .d({bus.cam_pclk, bus.cam_vsync, bus.cam_href}),
    .sync(ctl_sync), .rise(ctl_rise), .fall(ctl_fall)
  );

  cam_sync_edge #(.W(8)) u_data_sync (
    .clk(clk_i), .rst_n(rst_n), .d(bus.cam_data),
    .sync(data_sync), .rise(data_rise), .fall(data_fall)
  );

  assign unused_bits = ^{ctl_sync[2:1], ctl_rise[0], ctl_fall[2], data_rise, data_fall};

  logic pclk_rise, vs_rise, vs_fall, href_fall, href_s;
  assign pclk_rise = ctl_rise[2];
  assign vs_rise   = ctl_rise[1];
  assign vs_fall   = ctl_fall[1];
  assign href_fall = ctl_fall[0];
  assign href_s    = ctl_sync[0];

  logic en, en_prev, en_rise;
  assign en      = bus.capture_en_i;
  assign en_rise = en & ~en_prev;

  cam_state_t state, state_nx;
  logic       primed;
  logic [7:0] skip_cnt;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // The skip window only applies to the first frames after enable; later frames go straight to ACTIVE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = WAIT_VS;
      WAIT_VS: begin
        if (!en)         state_nx = IDLE;
        else if (vs_fall) state_nx = (FRAME_SKIP > 0 && !primed) ? SKIP : ACTIVE;
      end
      SKIP: begin
        if (!en) state_nx = IDLE;
        else if (vs_fall && (skip_cnt + 8'd1) == SKIP_N) state_nx = ACTIVE;
      end
      ACTIVE:  if (vs_rise) state_nx = en ? WAIT_VS : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      primed   <= 1'b0;
      skip_cnt <= '0;
      en_prev  <= 1'b0;
    end else begin
      en_prev <= en;
      if (state == IDLE)           primed <= 1'b0;
      else if (state_nx == ACTIVE) primed <= 1'b1;
      if (state != SKIP)           skip_cnt <= '0;
      else if (vs_fall)            skip_cnt <= skip_cnt + 8'd1;
    end
  end

  logic [XW:0]   x_cnt;
  logic [YW:0]   y_cnt, y_upd;
  logic          phase, line_adv, sample;
  logic [7:0]    hi_byte;
  logic          valid_q, sof_q, eol_q, done_q, lerr_q, ferr_q;
  rgb565_t       data_q;
  logic [XW-1:0] px_q;
  logic [YW-1:0] py_q;

  // y as seen after this cycle's href rule, so a coincident vsync rise checks the advanced count.
  always_comb begin
    line_adv = href_fall && (x_cnt != '0) && (y_cnt != Y_END);
    y_upd    = y_cnt + (YW+1)'(line_adv);
    sample   = (state == ACTIVE) && pclk_rise && href_s;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt <= '0; y_cnt <= '0; phase <= 1'b0; hi_byte <= '0;
      valid_q <= 1'b0; sof_q <= 1'b0; eol_q <= 1'b0; done_q <= 1'b0;
      lerr_q <= 1'b0; ferr_q <= 1'b0; data_q <= '0; px_q <= '0; py_q <= '0;
    end else begin
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      done_q  <= 1'b0;
      if (en_rise) begin
        lerr_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      if (state != ACTIVE) begin
        x_cnt <= '0;
        y_cnt <= '0;
        phase <= 1'b0;
      end else begin
        if (sample) begin
          if (x_cnt == X_END) begin
            lerr_q <= 1'b1;
          end else if (y_cnt != Y_END) begin
            if (!phase) begin
              hi_byte <= data_sync;
              phase   <= 1'b1;
            end else begin
              valid_q <= 1'b1;
              data_q  <= rgb565_t'({hi_byte, data_sync});
              px_q    <= x_cnt[XW-1:0];
              py_q    <= y_cnt[YW-1:0];
              sof_q   <= (x_cnt == '0) && (y_cnt == '0);
              eol_q   <= (x_cnt == X_LAST);
              x_cnt   <= x_cnt + (XW+1)'(1);
              phase   <= 1'b0;
            end
          end
        end
        if (href_fall) begin
          if (x_cnt != X_END || phase) lerr_q <= 1'b1;
          x_cnt <= '0;
          phase <= 1'b0;
          y_cnt <= y_upd;
        end
        if (vs_rise) begin
          if (y_upd == Y_END) done_q <= 1'b1;
          else                ferr_q <= 1'b1;
          x_cnt <= '0;
          y_cnt <= '0;
          phase <= 1'b0;
        end
      end
    end
  end

  assign bus.pixel_valid_o = valid_q;
  assign bus.pixel_data_o  = data_q;
  assign bus.pixel_x_o     = px_q;
  assign bus.pixel_y_o     = py_q;
  assign bus.sof_o         = sof_q;
  assign bus.eol_o         = eol_q;
  assign bus.frame_done_o  = done_q;
  assign bus.line_err_o    = lerr_q;
  assign bus.frame_err_o   = ferr_q;
  assign bus.busy_o        = (state != IDLE);

endmodule
